// File: rtl/sol_rom_loader.sv
// ROM download sequencer: splits host words into byte writes, range-checks them,
// tracks byte count/checksum and holds the CPUs in reset until a clean image is loaded.
module sol_rom_loader #(
  parameter logic [20:0] IMGSZ  = 21'h41000,
  parameter int          RELDLY = 16
) (
  input  logic        CL,
  input  logic        RSTn,
  input  logic        IOEN,
  input  logic [7:0]  IOIDX,
  input  logic        IOWR,
  input  logic [24:0] IOAD,
  input  logic [15:0] IODT,
  output logic        IOWAIT,
  output logic [19:0] DLAD,
  output logic [7:0]  DLDT,
  output logic        DLEN,
  output logic [20:0] BYTECNT,
  output logic [15:0] CKSUM,
  output logic        ERR,
  output logic        LOADED,
  output logic        CPURST
);

  typedef enum logic [1:0] {IDLE, LO, HI, RELEASE} state_t;

  state_t      state;
  logic [19:0] addr_q;
  logic [7:0]  hi_q;
  logic        ioen_q;
  logic        eval_pend;
  logic [15:0] rel_cnt;

  logic        strobe_ok;
  logic        ioen_rise;
  logic        ioen_fall;
  logic        addr_bad;
  logic        wr_byte;
  logic [7:0]  wr_data;
  logic [20:0] cnt_base;
  logic [15:0] ck_base;
  logic        err_base;

  assign strobe_ok = IOWR & IOEN & (IOIDX == 8'd0);
  assign ioen_rise = IOEN & ~ioen_q;
  assign ioen_fall = ~IOEN & ioen_q;
  // The last legal word starts at IMGSZ-2, so anything from IMGSZ-1 up is out of the map.
  assign addr_bad  = IOAD[0] | (IOAD >= ({4'd0, IMGSZ} - 25'd1));

  assign wr_byte = ((state == IDLE) & strobe_ok & ~addr_bad) | (state == LO);
  assign wr_data = (state == LO) ? hi_q : IODT[7:0];

  // A session start clears the running totals even if a byte lands on the same edge.
  assign cnt_base = ioen_rise ? 21'd0 : BYTECNT;
  assign ck_base  = ioen_rise ? 16'd0 : CKSUM;
  assign err_base = ioen_rise ? 1'b0 : ERR;

  always_ff @(posedge CL or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      addr_q    <= 20'd0;
      hi_q      <= 8'd0;
      ioen_q    <= 1'b0;
      eval_pend <= 1'b0;
      rel_cnt   <= 16'd0;
      IOWAIT    <= 1'b0;
      DLAD      <= 20'd0;
      DLDT      <= 8'd0;
      DLEN      <= 1'b0;
      BYTECNT   <= 21'd0;
      CKSUM     <= 16'd0;
      ERR       <= 1'b0;
      LOADED    <= 1'b0;
      CPURST    <= 1'b1;
    end else begin
      ioen_q <= IOEN;
      DLEN   <= wr_byte;
      ERR    <= err_base;
      if (wr_byte) begin
        BYTECNT <= (cnt_base == '1) ? cnt_base : cnt_base + 21'd1;
        CKSUM   <= ck_base + {8'd0, wr_data};
      end else begin
        BYTECNT <= cnt_base;
        CKSUM   <= ck_base;
      end

      if (ioen_rise) begin
        LOADED    <= 1'b0;
        CPURST    <= 1'b1;
        eval_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (strobe_ok) begin
            if (addr_bad) begin
              ERR <= 1'b1;
            end else begin
              DLAD   <= IOAD[19:0];
              DLDT   <= IODT[7:0];
              addr_q <= IOAD[19:0];
              hi_q   <= IODT[15:8];
              IOWAIT <= 1'b1;
              state  <= LO;
            end
          end else if ((ioen_fall | eval_pend) & ~ioen_rise) begin
            eval_pend <= 1'b0;
            if (!ERR && (BYTECNT == IMGSZ)) begin
              LOADED  <= 1'b1;
              rel_cnt <= 16'(RELDLY - 1);
              state   <= RELEASE;
            end
          end
        end
        LO: begin
          DLAD  <= addr_q + 20'd1;
          DLDT  <= hi_q;
          state <= HI;
          if (strobe_ok) ERR <= 1'b1;
          if (ioen_fall) eval_pend <= 1'b1;
        end
        HI: begin
          IOWAIT <= 1'b0;
          state  <= IDLE;
          if (strobe_ok) ERR <= 1'b1;
          if (ioen_fall) eval_pend <= 1'b1;
        end
        RELEASE: begin
          if (ioen_rise) begin
            rel_cnt <= 16'd0;
            state   <= IDLE;
          end else if (rel_cnt == 16'd0) begin
            CPURST <= 1'b0;
            state  <= IDLE;
          end else begin
            rel_cnt <= rel_cnt - 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sol_rom_loader.sv
// Randomized bench for sol_rom_loader: a queue of expected byte writes and running
// session totals are derived from the download rules and compared every cycle.
module tb_sol_rom_loader;

  localparam logic [20:0] IMG  = 21'h400;
  localparam int          RDLY = 16;

  logic        CL = 1'b0;
  logic        RSTn = 1'b0;
  logic        IOEN = 1'b0;
  logic [7:0]  IOIDX = 8'd0;
  logic        IOWR = 1'b0;
  logic [24:0] IOAD = 25'd0;
  logic [15:0] IODT = 16'd0;
  logic        IOWAIT;
  logic [19:0] DLAD;
  logic [7:0]  DLDT;
  logic        DLEN;
  logic [20:0] BYTECNT;
  logic [15:0] CKSUM;
  logic        ERR;
  logic        LOADED;
  logic        CPURST;

  sol_rom_loader #(.IMGSZ(IMG), .RELDLY(RDLY)) dut (
    .CL(CL), .RSTn(RSTn), .IOEN(IOEN), .IOIDX(IOIDX), .IOWR(IOWR), .IOAD(IOAD),
    .IODT(IODT), .IOWAIT(IOWAIT), .DLAD(DLAD), .DLDT(DLDT), .DLEN(DLEN),
    .BYTECNT(BYTECNT), .CKSUM(CKSUM), .ERR(ERR), .LOADED(LOADED), .CPURST(CPURST)
  );

  always #5 CL = ~CL;

  int cyc = 0;
  always @(posedge CL) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [19:0] ad;
    logic [7:0]  dt;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          m_cnt = 0;
  logic [15:0] m_ck = 16'd0;
  bit          m_err = 1'b0;
  int          sess_bytes = 0;
  int          busy_end = 0;
  int          acc_e = -100;
  int          clear_at = -1;
  bit          exp_dlen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Expected byte-bus activity and running totals, sampled mid-cycle.
  always @(negedge CL) begin
    if (cyc == clear_at) begin
      m_cnt = 0;
      m_ck  = 16'd0;
    end
    exp_dlen = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("dlen", {31'd0, DLEN}, {31'd0, exp_dlen});
    if (exp_dlen) begin
      check("dlad", {12'd0, DLAD}, {12'd0, exp_q[0].ad});
      check("dldt", {24'd0, DLDT}, {24'd0, exp_q[0].dt});
      m_cnt++;
      m_ck = m_ck + {8'd0, exp_q[0].dt};
      void'(exp_q.pop_front());
    end
    check("bytecnt", {11'd0, BYTECNT}, m_cnt);
    check("cksum", {16'd0, CKSUM}, {16'd0, m_ck});
    check("iowait", {31'd0, IOWAIT}, {31'd0, (cyc >= acc_e) && (cyc <= acc_e + 1)});
  end

  task automatic wait_cyc(input int x);
    while (cyc < x) @(negedge CL);
  endtask

  // Called at a negedge; the strobe is sampled on the next rising edge.
  task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [15:0] d,
                        input int gap);
    int  e = cyc + 1;
    wr_t w;
    IOWR  = 1'b1;
    IOIDX = idx;
    IOAD  = a;
    IODT  = d;
    if (IOEN && idx == 8'd0) begin
      if (e < busy_end) m_err = 1'b1;
      else if (a[0] || a >= {4'd0, IMG} - 25'd1) m_err = 1'b1;
      else begin
        busy_end = e + 3;
        acc_e    = e;
        w.cyc = e;     w.ad = a[19:0];         w.dt = d[7:0];  exp_q.push_back(w);
        w.cyc = e + 1; w.ad = a[19:0] + 20'd1; w.dt = d[15:8]; exp_q.push_back(w);
        sess_bytes += 2;
      end
    end
    @(negedge CL);
    IOWR = 1'b0;
    repeat (gap) @(negedge CL);
  endtask

  task automatic start_session();
    IOEN       = 1'b1;
    clear_at   = cyc + 1;
    m_err      = 1'b0;
    sess_bytes = 0;
    repeat (2) @(negedge CL);
    check("start_loaded", {31'd0, LOADED}, 32'd0);
    check("start_cpurst", {31'd0, CPURST}, 32'd1);
    check("start_err", {31'd0, ERR}, 32'd0);
  endtask

  task automatic end_session();
    int f, ev;
    bit exp_ld;
    IOEN   = 1'b0;
    f      = cyc + 1;
    ev     = (f < busy_end) ? busy_end : f;
    exp_ld = !m_err && (sess_bytes == int'(IMG));
    wait_cyc(ev - 1);
    check("loaded_early", {31'd0, LOADED}, 32'd0);
    wait_cyc(ev);
    check("loaded", {31'd0, LOADED}, {31'd0, exp_ld});
    check("err_end", {31'd0, ERR}, {31'd0, m_err});
    wait_cyc(ev + RDLY - 1);
    check("cpurst_hold", {31'd0, CPURST}, 32'd1);
    wait_cyc(ev + RDLY);
    check("cpurst_rel", {31'd0, CPURST}, {31'd0, !exp_ld});
    repeat (2) @(negedge CL);
  endtask

  task automatic full_load(input int nbytes, input bit rnd, input bit junk, input int last_gap);
    logic [24:0] a;
    logic [15:0] d;
    for (int i = 0; i < nbytes; i += 2) begin
      a = 25'(i);
      d = rnd ? 16'($urandom) : {a[8:1], a[7:0]};
      if (junk && $urandom_range(0, 7) == 0)
        strobe(8'($urandom_range(1, 255)), 25'($urandom), 16'($urandom), 0);
      strobe(8'd0, a, d, (i + 2 >= nbytes) ? last_gap : int'($urandom_range(2, 4)));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    int          f, ev;
    logic [24:0] a;
    logic [7:0]  idx;
    logic [24:0] last;

    repeat (2) @(negedge CL);
    check("rst_iowait", {31'd0, IOWAIT}, 32'd0);
    check("rst_dlad", {12'd0, DLAD}, 32'd0);
    check("rst_dldt", {24'd0, DLDT}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    check("rst_loaded", {31'd0, LOADED}, 32'd0);
    check("rst_cpurst", {31'd0, CPURST}, 32'd1);
    RSTn = 1'b1;
    @(negedge CL);

    // Strobe outside a session is ignored.
    strobe(8'd0, 25'h10, 16'h1234, 2);
    check("noen_err", {31'd0, ERR}, 32'd0);

    // Single word at the top of the map, then odd and out-of-range addresses.
    start_session();
    last = {4'd0, IMG} - 25'd2;
    strobe(8'd0, last, 16'hA55A, 0);
    check("single_lo_dt", {24'd0, DLDT}, 32'h5A);
    check("single_lo_ad", {12'd0, DLAD}, {7'd0, last});
    check("single_wait1", {31'd0, IOWAIT}, 32'd1);
    @(negedge CL);
    check("single_hi_dt", {24'd0, DLDT}, 32'hA5);
    check("single_hi_ad", {12'd0, DLAD}, {7'd0, last} + 32'd1);
    check("single_wait2", {31'd0, IOWAIT}, 32'd1);
    @(negedge CL);
    check("single_wait3", {31'd0, IOWAIT}, 32'd0);
    check("single_dlen_off", {31'd0, DLEN}, 32'd0);
    strobe(8'd0, 25'h11, 16'hFFFF, 2);
    check("odd_err", {31'd0, ERR}, 32'd1);
    strobe(8'd0, {4'd0, IMG}, 16'hFFFF, 2);
    strobe(8'd0, 25'h1000000, 16'hFFFF, 2);
    end_session();

    // Non-zero index is silently ignored.
    start_session();
    for (int i = 0; i < 6; i++) strobe(8'(i + 1), 25'(2 * i), 16'($urandom), 2);
    check("idx_err", {31'd0, ERR}, 32'd0);
    end_session();

    // Clean full load with the address-pattern data.
    start_session();
    full_load(int'(IMG), 1'b0, 1'b1, 2);
    end_session();

    // Errors poison a session even if the image is complete.
    start_session();
    strobe(8'd0, 25'h11, 16'h0101, 2);
    strobe(8'd0, {4'd0, IMG}, 16'h0202, 2);
    full_load(int'(IMG), 1'b1, 1'b0, 2);
    end_session();

    // Short load fails; a new session clears; reload ends with IOEN dropping mid-pair.
    start_session();
    full_load(int'(IMG) - 2, 1'b1, 1'b0, 2);
    end_session();
    start_session();
    check("clear_cnt", {11'd0, BYTECNT}, 32'd0);
    check("clear_ck", {16'd0, CKSUM}, 32'd0);
    full_load(int'(IMG), 1'b1, 1'b1, 0);
    end_session();

    // Strobe one cycle after an accepted strobe.
    start_session();
    strobe(8'd0, 25'h20, 16'h1111, 0);
    strobe(8'd0, 25'h40, 16'h2222, 2);
    check("b2b_err", {31'd0, ERR}, 32'd1);
    end_session();

    // New session while the CPU release is counting down.
    start_session();
    full_load(int'(IMG), 1'b1, 1'b0, 2);
    IOEN = 1'b0;
    f  = cyc + 1;
    ev = (f < busy_end) ? busy_end : f;
    wait_cyc(ev);
    check("abort_loaded_pre", {31'd0, LOADED}, 32'd1);
    wait_cyc(ev + 5);
    start_session();
    wait_cyc(ev + RDLY + 4);
    check("abort_cpurst", {31'd0, CPURST}, 32'd1);
    check("abort_loaded", {31'd0, LOADED}, 32'd0);
    end_session();

    // Random mix of legal, illegal, foreign-index and too-fast strobes.
    start_session();
    for (int i = 0; i < 200; i++) begin
      idx = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      case ($urandom_range(0, 5))
        0:       a = 25'($urandom_range(0, int'(IMG) / 2 - 1) * 2 + 1);
        1:       a = 25'(int'(IMG) + 2 * $urandom_range(0, 1000));
        default: a = 25'($urandom_range(0, int'(IMG) / 2 - 1) * 2);
      endcase
      strobe(idx, a, 16'($urandom), int'($urandom_range(0, 4)));
    end
    end_session();

    // Asynchronous reset while the low byte of a pair is on the bus.
    start_session();
    strobe(8'd0, 25'h100, 16'hBEEF, 0);
    #2;
    RSTn = 1'b0;
    IOEN = 1'b0;
    exp_q.delete();
    m_cnt    = 0;
    m_ck     = 16'd0;
    m_err    = 1'b0;
    busy_end = 0;
    acc_e    = -100;
    #1;
    check("arst_dlen", {31'd0, DLEN}, 32'd0);
    check("arst_dlad", {12'd0, DLAD}, 32'd0);
    check("arst_dldt", {24'd0, DLDT}, 32'd0);
    check("arst_cnt", {11'd0, BYTECNT}, 32'd0);
    check("arst_ck", {16'd0, CKSUM}, 32'd0);
    check("arst_iowait", {31'd0, IOWAIT}, 32'd0);
    check("arst_cpurst", {31'd0, CPURST}, 32'd1);
    repeat (3) @(negedge CL);
    RSTn = 1'b1;
    repeat (4) @(negedge CL);
    check("post_rst_cnt", {11'd0, BYTECNT}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sol_rom_loader.md
# sol_rom_loader

Download sequencer that sits directly upstream of the ROM bank modules: it accepts the 16-bit host download stream, splits each word into two byte writes on the shared `DLAD`/`DLDT`/`DLEN` bus, and range-checks every address against the 0x00000–0x40FFF image map. It also keeps a byte count and checksum, reports load completion, and holds the CPUs in reset until a complete, error-free image has been written.

## Interface
Parameters:
- `IMGSZ`, 21'h41000: required image size in bytes; valid byte addresses are 0 to IMGSZ-1.
- `RELDLY`, 16: cycles from `LOADED` rising to `CPURST` release.

Ports:
- `CL` in 1: single clock; also drives the ROM write port (`DLCL`).
- `RSTn` in 1: asynchronous active-low reset.
- `IOEN` in 1: download session active (level).
- `IOIDX` in 8: download index; only 8'd0 is the ROM image.
- `IOWR` in 1: one-cycle word write strobe.
- `IOAD` in 25: byte address of the word (must be even).
- `IODT` in 16: word data; [7:0] goes to `IOAD`, [15:8] to `IOAD`+1.
- `IOWAIT` out 1: busy, host must not strobe.
- `DLAD` out 20: byte write address to ROMs.
- `DLDT` out 8: byte write data.
- `DLEN` out 1: byte write enable, one cycle per byte.
- `BYTECNT` out 21: bytes written this session.
- `CKSUM` out 16: modulo-2^16 sum of bytes written this session.
- `ERR` out 1: sticky session error.
- `LOADED` out 1: a complete, valid image is present.
- `CPURST` out 1: CPU reset hold, active high.

## Operation
- Reset values: `IOWAIT`=0, `DLAD`=0, `DLDT`=0, `DLEN`=0, `BYTECNT`=0, `CKSUM`=0, `ERR`=0, `LOADED`=0, `CPURST`=1. The FSM resets to IDLE and the release counter to 0.
- FSM states are IDLE, LO, HI, RELEASE.
- IDLE: a strobe is accepted when `IOWR`=1, `IOEN`=1 and `IOIDX`=0. On accept, latch `IOAD` and `IODT`, then go to LO.
- Accepted strobe with `IOAD[0]`=1 or `IOAD`≥IMGSZ-1: set `ERR`, drop the word, stay IDLE, no `DLEN`.
- A strobe with `IOIDX`≠0, or with `IOEN`=0, is ignored silently. Counters and `ERR` are not touched.
- LO: `DLEN`=1, `DLAD`=A[19:0], `DLDT`=D[7:0]. Then go to HI.
- HI: `DLEN`=1, `DLAD`=A+1, `DLDT`=D[15:8]. Then go to IDLE.
- Each written byte adds 1 to `BYTECNT` and adds the byte zero-extended to `CKSUM`, both on the cycle its `DLEN` is high. `CKSUM` wraps modulo 2^16. `BYTECNT` saturates at 2^21-1.
- Rising edge of `IOEN` (session start): clear `BYTECNT`, `CKSUM`, `ERR` and `LOADED`, and set `CPURST`=1. This takes priority over any completion in the same cycle.
- Falling edge of `IOEN` (session end):
  - If the FSM is in LO or HI, the pair completes first and evaluation happens on the cycle the FSM returns to IDLE.
  - Evaluation: if `ERR`=0 and `BYTECNT`=IMGSZ, set `LOADED`=1 and enter RELEASE. Otherwise `LOADED` stays 0, `CPURST` stays 1 and the FSM stays IDLE.
- RELEASE: count RELDLY cycles, then drive `CPURST`=0 and return to IDLE.
  - `IOEN` rising during RELEASE aborts it: counter cleared, `CPURST`=1, session start applied.
- Duplicate addresses are not detected; they count twice and will normally fail the size check.

## Timing
- `IOWR` sampled at edge t in IDLE gives `DLEN`=1 with the low byte at t+1, and `DLEN`=1 with the high byte at t+2. The FSM is back in IDLE at t+3.
- `IOWAIT` is registered: 1 during t+1 and t+2, 0 from t+3. Maximum rate is one word per 3 cycles.
- A strobe while `IOWAIT`=1 is a protocol violation: set `ERR`, drop the word, and the in-flight pair completes unaffected.
- `DLAD`, `DLDT`, `BYTECNT` and `CKSUM` are registered and update together with `DLEN`. `DLAD`/`DLDT` hold their last value when `DLEN`=0.
- `LOADED` rises 1 cycle after the evaluating IDLE cycle. `CPURST` falls RELDLY cycles after `LOADED` rises.
- `RSTn` asserted mid-pair: outputs go to reset values immediately (asynchronously) and any second byte not yet written is lost.

## Test plan
- Full load, index 0, addresses 0..0x40FFE step 2, data = {addr[8:1], addr[7:0]}, gap 3 cycles, then `IOEN` falls -> 266240 `DLEN` pulses, `BYTECNT`=21'h41000, `CKSUM` equal to the model sum, `ERR`=0, `LOADED`=1, `CPURST` falls exactly 16 cycles after `LOADED`.
- Single word `IOAD`=0x3C000, `IODT`=16'hA55A -> t+1: `DLAD`=0x3C000, `DLDT`=8'h5A; t+2: `DLAD`=0x3C001, `DLDT`=8'hA5; `IOWAIT`=1 at t+1 and t+2 only.
- Odd address 0x00011, then address 0x41000 -> no `DLEN`, `ERR`=1; a full load in the same session still ends with `LOADED`=0 and `CPURST`=1.
- Strobe at t+1 after an accepted strobe at t -> exactly two `DLEN` pulses, `ERR`=1. Separately, `IOIDX`=1 strobes -> no writes and `ERR`=0.
- Short load (0x40FFE bytes) -> `LOADED`=0. Then a new session (`IOEN` rising) -> counters cleared. Then a full reload -> `LOADED`=1.
- `RSTn` low at t+1 of a pair -> all outputs at reset values, no second `DLEN`. `IOEN` rising during RELEASE -> `CPURST` stays 1 and `LOADED`=0.
